// File: rtl/opsg_pkg.sv
// opsg_pkg
// Shared constants for the OPSG sound generator and its output stages.
//   OPSG_AUDIO_WIDTH : width of one audio channel sample
//   OPSG_BCLK_DIV    : default system clocks per I2S bit-clock half-period
//   OPSG_SLOT_COUNT  : I2S slots per frame (left + right words)
//   opsg_cw()        : counter width helper that never returns zero
package opsg_pkg;

    localparam int OPSG_AUDIO_WIDTH = 16;
    localparam int OPSG_BCLK_DIV    = 4;
    localparam int OPSG_SLOT_COUNT  = 2 * OPSG_AUDIO_WIDTH;

    // Width of a counter that must hold 0..n-1; a divide-by-1 counter
    // still needs one bit so the declaration stays legal.
    function automatic int opsg_cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/opsg_i2s_clkgen.sv
// opsg_i2s_clkgen
// Bit-clock generator for the OPSG I2S output stage. Divides the system
// clock by 2*BCLK_DIV and flags the clk cycle on which bclk is about to
// toggle, so downstream registers change together with bclk.
// Ports:
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   o_bclk  : registered bit clock (0 after reset)
//   o_fall  : high for the one clk whose edge takes bclk 1->0
//   o_rise  : high for the one clk whose edge takes bclk 0->1
module opsg_i2s_clkgen
    import opsg_pkg::*;
#(
    parameter int BCLK_DIV = OPSG_BCLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_bclk,
    output logic o_fall,
    output logic o_rise
);

    localparam int CW = opsg_cw(BCLK_DIV);

    logic [CW-1:0] r_div_cnt;
    logic          r_bclk;
    logic          w_wrap;

    assign w_wrap = (r_div_cnt == CW'(BCLK_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Events are decoded from the current state, so the edge that toggles
    // bclk is also the edge on which consumers see the event.
    assign o_bclk = r_bclk;
    assign o_fall = w_wrap &  r_bclk;
    assign o_rise = w_wrap & ~r_bclk;

endmodule

// File: rtl/opsg_i2s.sv
// opsg_i2s
// Serial I2S output stage for the OPSG sound generator. Latches both
// channels once per frame and shifts them out MSB first to a DAC.
// Build option: define OPSG_I2S_LEFT_JUSTIFIED_EN for left-justified
// framing (no one-bit delay); default is standard I2S.
// Ports:
//   clk          : system clock (only clock)
//   rst          : asynchronous active-high reset
//   audio_left   : left sample, sampled only at the frame wrap
//   audio_right  : right sample, sampled only at the frame wrap
//   bclk         : bit clock, DAC samples sdata on its rising edge
//   lrck         : word select, 0 = left, 1 = right
//   sdata        : serial data, MSB first
//   sample_req   : one-clk pulse when new inputs are latched
module opsg_i2s
    import opsg_pkg::*;
#(
    parameter int BCLK_DIV     = OPSG_BCLK_DIV,
    parameter int SAMPLE_WIDTH = OPSG_AUDIO_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] audio_left,
    input  logic [SAMPLE_WIDTH-1:0] audio_right,
    output logic                    bclk,
    output logic                    lrck,
    output logic                    sdata,
    output logic                    sample_req
);

    localparam int W     = SAMPLE_WIDTH;
    localparam int SLOTS = 2 * W;
    localparam int SW    = opsg_cw(SLOTS);

    logic          w_fall;
    logic          w_rise;
    logic [SW-1:0] r_slot;
    logic [W-1:0]  r_shl;
    logic [W-1:0]  r_shr;
    logic          r_lrck;
    logic          r_sdata;
    logic          r_sample_req;

    logic            w_slot_last;
    logic [SW-1:0]   w_slot_next;
    logic [SW-1:0]   w_bit_idx;
    logic [2*W-1:0]  w_word_cur;
    logic            w_bit;

    opsg_i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_bclk (bclk),
        .o_fall (w_fall),
        .o_rise (w_rise)
    );

    assign w_slot_last = (r_slot == SW'(SLOTS - 1));
    assign w_slot_next = w_slot_last ? '0 : r_slot + 1'b1;
    assign w_word_cur  = {r_shl, r_shr};

`ifdef OPSG_I2S_LEFT_JUSTIFIED_EN
    // The new slot's own bit goes out; at the wrap that bit belongs to the
    // frame being latched right now, so take it from the inputs.
    logic [2*W-1:0] w_word_new;
    assign w_word_new = w_slot_last ? {audio_left, audio_right} : w_word_cur;
    assign w_bit_idx  = SW'(SLOTS - 1) - w_slot_next;
    assign w_bit      = w_word_new[w_bit_idx];
`else
    // One-bclk delay: the bit of the slot just finished goes out. At the
    // wrap the shadows still hold the old frame, which yields the previous
    // right LSB in slot 0.
    assign w_bit_idx = SW'(SLOTS - 1) - r_slot;
    assign w_bit     = w_word_cur[w_bit_idx];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot       <= SW'(SLOTS - 1);
            r_shl        <= '0;
            r_shr        <= '0;
            r_lrck       <= 1'b0;
            r_sdata      <= 1'b0;
            r_sample_req <= 1'b0;
        end else begin
            r_sample_req <= 1'b0;
            if (w_fall) begin
                r_slot  <= w_slot_next;
                r_lrck  <= (w_slot_next >= SW'(W));
                r_sdata <= w_bit;
                if (w_slot_last) begin
                    r_shl        <= audio_left;
                    r_shr        <= audio_right;
                    r_sample_req <= 1'b1;
                end
            end
        end
    end

    // Rise and fall share the divider wrap and must never coincide.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(w_fall && w_rise));
        end
    end

    assign lrck       = r_lrck;
    assign sdata      = r_sdata;
    assign sample_req = r_sample_req;

endmodule

// File: tb/tb_opsg_i2s.sv
module tb_opsg_i2s;

    localparam int D    = 2;
    localparam int W    = 16;
    localparam int S    = 2 * W;
    localparam int FALL = 2 * D;
`ifdef OPSG_I2S_LEFT_JUSTIFIED_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] audio_left  = '0;
    logic [W-1:0] audio_right = '0;
    logic         bclk, lrck, sdata, sample_req;

    opsg_i2s #(.BCLK_DIV(D), .SAMPLE_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .bclk        (bclk),
        .lrck        (lrck),
        .sdata       (sdata),
        .sample_req  (sample_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: clk edges since reset release, and the frame words
    // latched at each frame start (frame f begins at fall event f*S+1).
    int             e = 0;
    logic [2*W-1:0] frames[$];

    always @(posedge clk) begin
        if (rst) begin
            e = 0;
            frames.delete();
        end else begin
            e++;
            if (e % FALL == 0 && ((e / FALL) - 1) % S == 0)
                frames.push_back({audio_left, audio_right});
        end
    end

    function automatic logic model_sdata(input int n);
        int s, f;
        if (n == 0) return 1'b0;
        s = (n - 1) % S;
        f = (n - 1) / S;
`ifdef OPSG_I2S_LEFT_JUSTIFIED_EN
        return frames[f][S-1-s];
`else
        if (s == 0) return (f > 0) ? frames[f-1][0] : 1'b0;
        return frames[f][S-s];
`endif
    endfunction

    logic obs [0:1023];
    int   last_req = -1;

    always @(negedge clk) begin
        int n;
        logic [3:0] ex;
        if (rst) begin
            chk("reset_outputs", {28'd0, bclk, lrck, sdata, sample_req}, 32'd0);
            last_req = -1;
        end else begin
            n = e / FALL;
            ex[3] = ((e / D) % 2) == 1;
            ex[2] = (n > 0) && (((n - 1) % S) >= W);
            ex[1] = model_sdata(n);
            ex[0] = (n > 0) && (e % FALL == 0) && (((n - 1) % S) == 0);
            chk("bclk_lrck_sdata_req", {28'd0, bclk, lrck, sdata, sample_req}, {28'd0, ex});
            if (e % FALL == 0 && n > 0 && n < 1024) obs[n] = sdata;
            if (sample_req) begin
                if (last_req < 0) chk("first_req_delay", e, FALL);
                else chk("req_interval", e - last_req, FALL * S);
                last_req = e;
            end
        end
    end

    task automatic wait_e(input int target);
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (e == target) break;
        end
        if (k == 5000) chk("timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [W-1:0] obs_word(input int start_n);
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[W-1-i] = obs[start_n + i];
        return w;
    endfunction

    initial begin
        logic [W-1:0] nl, nr;
        int target;
        audio_left  = 16'hA5F0;
        audio_right = 16'h0F0F;
        repeat (3) @(negedge clk);
        #1 rst = 0;

        // Change left during slot 5 of the first frame.
        wait_e(FALL * 6);
        #1 audio_left = 16'h1234;
        wait_e(FALL * (2 * S + 2));
        chk("frame0_left",  {16'd0, obs_word(1 + OFF)},      32'h0000A5F0);
        chk("frame0_right", {16'd0, obs_word(W + 1 + OFF)},  32'h00000F0F);
        chk("frame1_left",  {16'd0, obs_word(S + 1 + OFF)},  32'h00001234);
        chk("frame1_right", {16'd0, obs_word(S + W + 1 + OFF)}, 32'h00000F0F);

        // Asynchronous reset at slot 20 of the next frame.
        target = (((e / FALL) - 1) / S + 1) * S + 21;
        wait_e(FALL * target);
        chk("lrck_slot20", {31'd0, lrck}, 32'd1);
        #2 rst = 1;
        #1 chk("async_reset", {28'd0, bclk, lrck, sdata, sample_req}, 32'd0);
        nl = W'($urandom);
        nr = W'($urandom);
        audio_left  = nl;
        audio_right = nr;
        repeat (2) @(negedge clk);
        #1 rst = 0;
        wait_e(FALL * (S + W + 2));
        chk("restart_left",  {16'd0, obs_word(1 + OFF)},     {16'd0, nl});
        chk("restart_right", {16'd0, obs_word(W + 1 + OFF)}, {16'd0, nr});

`ifdef OPSG_I2S_LEFT_JUSTIFIED_EN
        // Left-justified: 8001 puts ones in slots 0 and 15 only.
        audio_left = 16'h8001;
        target = (((e / FALL) - 1) / S + 2) * S + 1;
        wait_e(FALL * (target + W));
        chk("lj_8001", {16'd0, obs_word(target)}, 32'h00008001);
`endif

        // Randomized inputs with occasional resets; the compare process
        // checks every cycle against the model.
        repeat (4000) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) audio_left  = W'($urandom);
            if ($urandom_range(0, 7) == 0) audio_right = W'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                rst = 1;
                repeat (2) @(negedge clk);
                #1 rst = 0;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/opsg_i2s.md
# opsg_i2s

Serial audio output stage placed directly downstream of the OPSG sound generator. Takes the parallel 16-bit `audio_left`/`audio_right` sums and streams them to an external DAC as an I2S frame. Generates its own bit clock (`bclk`) and word select (`lrck`) from the system clock. Latches both channels once per frame so a frame never mixes old and new samples.

## Interface
- `BCLK_DIV`, 4: system clocks per `bclk` half-period; legal range is 1 or greater.
- `SAMPLE_WIDTH`, 16: bits per channel word; legal range is 8..32; a frame is 2×`SAMPLE_WIDTH` slots.
- `clk` in 1: system clock; the block's only clock.
- `rst` in 1: asynchronous, active-high reset.
- `audio_left` in `SAMPLE_WIDTH`: left sample; may change at any time.
- `audio_right` in `SAMPLE_WIDTH`: right sample; may change at any time.
- `bclk` out 1: serial bit clock; the DAC samples `sdata` on the `bclk` rising edge.
- `lrck` out 1: word select; 0 = left, 1 = right.
- `sdata` out 1: serial data, MSB first.
- `sample_req` out 1: one-`clk` pulse when new inputs are latched.

## Operation
- Divider counter `div_cnt` (0..`BCLK_DIV`-1):
  - On reaching `BCLK_DIV`-1 it returns to 0 and toggles `bclk`.
  - A toggle from 1→0 is a fall event; from 0→1 is a rise event.
- Slot counter `slot` (0..2W-1, where W = `SAMPLE_WIDTH`) advances on every fall event and wraps 2W-1→0.
- On the wrap into slot 0:
  - `audio_left`/`audio_right` are copied into shadow registers `shl`/`shr`.
  - `sample_req` = 1 for that one `clk`.
- Frame word is `{shl, shr}`. The left-justified bit for slot s is word bit (2W-1-s).
- `lrck` is registered on the fall event: 1 when the new slot ≥ W, else 0.
- I2S mode (default): `sdata` on each fall event takes the left-justified bit of the *previous* slot (one-`bclk` delay).
  - Slot 0 therefore carries the LSB of the previous frame's right word.
  - The left MSB appears in slot 1.
- Only fall events change `lrck` and `sdata`. Both are stable across the `bclk` rising edge.
- Inputs are sampled only at the wrap. Input changes mid-frame take effect in the next frame.
- Reset (asynchronous, takes effect immediately and aborts any frame in progress):
  - `bclk`, `lrck`, `sdata`, `sample_req` = 0.
  - `div_cnt` = 0, `shl` = `shr` = 0.
  - `slot` = 2W-1, so the first fall event after release wraps to slot 0 and latches the inputs.

## Timing
- `bclk` period = 2×`BCLK_DIV` clk cycles.
- Frame period = 2×`BCLK_DIV`×2W clk cycles. Defaults give 256 clk cycles.
- First fall event after `rst` deasserts: 2×`BCLK_DIV` clk cycles after release (first rise at `BCLK_DIV`).
- `sample_req` is asserted in the same cycle that `shl`/`shr` load. It repeats exactly once per frame period.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `BCLK_DIV`=1: `bclk` toggles every clk, and fall events occur every 2 clk.

## Configuration
- Macro `OPSG_I2S_LEFT_JUSTIFIED_EN`:
  - Defined: left-justified format. There is no one-bit delay; slot s outputs word bit (2W-1-s) directly, so the left MSB is in slot 0, coincident with `lrck` falling.
  - Undefined: standard I2S as described in Operation.
- Everything else is identical in both builds.

## Structure
- Shared package `opsg_pkg` holds:
  - `OPSG_AUDIO_WIDTH` = 16.
  - Default `BCLK_DIV`.
  - Slot-count helper constant 2×`OPSG_AUDIO_WIDTH`.
- Sub-module `opsg_i2s_clkgen` holds `div_cnt`, `bclk`, and the one-clk fall/rise event pulses.
- The top level holds the slot counter, shadow registers, `lrck`, `sdata`, and `sample_req`.

## Test plan
All scenarios use `BCLK_DIV`=2 and W=16 unless noted.
1. **Reset state:** assert `rst` with no clk edge → `bclk`=`lrck`=`sdata`=`sample_req`=0 immediately. Release → first `sample_req` pulse 4 clk later.
2. **I2S data:** `audio_left`=16'hA5F0, `audio_right`=16'h0F0F → in the first frame:
   - Slots 1..16 (`lrck`=0 for slots 0..15) shift out A5F0 MSB first.
   - Slots 17..31 plus the next slot 0 shift out 0F0F.
   - All bits are stable at every `bclk` rise.
3. **Mid-frame change:** change `audio_left` to 16'h1234 during slot 5 → the current frame still emits A5F0; the next frame emits 1234.
4. **Rates:** `sample_req` pulses exactly every 128 clk; `bclk` period is 4 clk; `lrck` toggles every 64 clk.
5. **Left-justified build:** with `OPSG_I2S_LEFT_JUSTIFIED_EN` defined, left=16'h8001 → `sdata`=1 in slot 0 and slot 15, 0 in slots 1..14.
6. **Mid-frame reset:** pulse `rst` at slot 20 → outputs go to 0 asynchronously. After release, the frame restarts at slot 0 and latches current inputs, and there is no truncated-frame residue.
